sccb_slave_regfile: RTL and testbench
=====================================

SCCB_SLAVE_REGFILE -- requirements
Module: sccb_slave_regfile

Interface
REQ-001 Parameter DEV_ADDR, 7'h21, 7-bit SCCB device address; write byte 0x42, read byte 0x43.
REQ-002 Parameter REG_RESET, 8'h00, reset value of every register-file entry.
REQ-003 iCLK  input  1  system clock, ≥50x the SCL rate; the only clock.
REQ-004 iRST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 I2C_SCLK  input  1  SCCB clock from the master, asynchronous to iCLK.
REQ-006 I2C_SDAT  inout  1  SCCB data, open-drain: the block drives only 0 or Z.
REQ-007 iHOST_ADDR  input  8  host read address into the register file.
REQ-008 oHOST_DATA  output  8  register file content at iHOST_ADDR, registered with 1-cycle latency.
REQ-009 oWR_STB  output  1  one-cycle pulse per register byte written over SCCB.
REQ-010 oWR_ADDR  output  8  register address of the last write; valid while oWR_STB is high and held afterwards.
REQ-011 oWR_DATA  output  8  data of the last write; valid while oWR_STB is high and held afterwards.
REQ-012 oBUSY  output  1  high from an addressed START until STOP.

Function
REQ-013 SCL and SDA SHALL each pass through a 2-flop synchronizer; edges and START/STOP conditions are detected on the synchronized values.
REQ-014 START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both SHALL be recognised in every state.
REQ-015 States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-016 START from any state → ADDR, bit counter cleared. This covers repeated START.
REQ-017 STOP from any state → IDLE, SDA released.
REQ-018 Bits SHALL be sampled on the rising SCL edge, MSB first. SDA SHALL change only after a detected falling SCL edge.
REQ-019 ADDR:
- After 8 bits, if byte[7:1] == DEV_ADDR → ADDR_ACK, driving SDA low from the 8th falling edge until the 9th falling edge.
- Otherwise → IGNORE with SDA released. IGNORE is left only by START or STOP.
REQ-020 After ADDR_ACK: R/W=0 → SUB; R/W=1 → RDATA, loading the shift register with mem[ptr].
REQ-021 SUB: the 8-bit byte SHALL load ptr, then ACK (SUB_ACK) → WDATA.
REQ-022 WDATA, on each completed byte:
- write mem[ptr];
- pulse oWR_STB with oWR_ADDR = ptr, oWR_DATA = byte;
- increment ptr modulo 256 (0xFF wraps to 0x00);
- ACK (WDATA_ACK), then continue in WDATA.
REQ-023 RDATA: drive SDA low for 0 bits and Z for 1 bits across 8 bits. After the 8th falling edge release SDA → RDATA_ACK and sample the master bit on the 9th rising edge.
- Master ACK (0): ptr increments modulo 256 and mem[ptr] is reloaded.
- Master NACK (1): → IGNORE.
REQ-024 ptr SHALL persist across transactions, so a write containing only the sub-address followed by a repeated-START read returns mem[sub].
REQ-025 START or STOP arriving mid-byte SHALL discard the partial byte, with no write and no ptr change.
REQ-026 The register file is 256x8. A host read and an SCCB write to the same address in the same cycle SHALL return the old data on oHOST_DATA.

Reset
REQ-027 On iRST_N low, asynchronously: state = IDLE, SDA = Z, ptr = 0, counters = 0, oWR_STB = 0, oWR_ADDR = 0, oWR_DATA = 0, oBUSY = 0, oHOST_DATA = 0.
REQ-028 All mem entries = REG_RESET. Reset asserted mid-transaction SHALL release SDA immediately.
REQ-029 After reset deasserts, the block SHALL ignore bus activity until the first START.

Structure
REQ-030 Package sccb_pkg SHALL hold the state encoding, the write/read address byte constants and the bit-count width.
REQ-031 Sub-module sccb_sync_edge SHALL hold the synchronizers, the SCL rise/fall detectors and the START/STOP detectors.

Verification
REQ-032 Write of 0x42, 0x12, 0x46, then STOP → 3 ACKs; oWR_STB pulses once with oWR_ADDR = 0x12, oWR_DATA = 0x46; iHOST_ADDR = 0x12 gives oHOST_DATA = 0x46.
REQ-033 Address byte 0x40, then 0x12, 0x46 → no ACK on any byte; SDA never driven low; no oWR_STB; mem unchanged.
REQ-034 Write 0x42, 0x12; repeated START; 0x43; read 1 byte with NACK → SDA carries 0x46; master NACK; ptr stays 0x12.
REQ-035 Write 0x42, 0xFF, 0xAA, 0xBB → mem[0xFF] = 0xAA, mem[0x00] = 0xBB; two oWR_STB pulses.
REQ-036 STOP after 4 data bits of WDATA → no write; state IDLE; oBUSY = 0.
REQ-037 iRST_N pulsed low during the ADDR_ACK low phase → SDA = Z within the same cycle; state IDLE; all mem = REG_RESET.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB slave register file: FSM encoding,
// bit-count width and the default write/read address bytes.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } sccb_state_e;

    localparam int BIT_CNT_W = 4;
    localparam logic [BIT_CNT_W-1:0] BYTE_BITS = BIT_CNT_W'(8);

    localparam logic [7:0] SCCB_WR_BYTE = 8'h42;
    localparam logic [7:0] SCCB_RD_BYTE = 8'h43;

    // Upper seven bits of the address byte select the device; bit 0 is R/W.
    function automatic logic addr_hit(input logic [7:0] addr_byte,
                                      input logic [6:0] dev_addr);
        return addr_byte[7:1] == dev_addr;
    endfunction

endpackage

// File: rtl/sccb_slave_regfile_if.sv
// Host-side view of the register file: read port plus write notification.
interface sccb_slave_regfile_if;

    logic [7:0] iHOST_ADDR;
    logic [7:0] oHOST_DATA;
    logic       oWR_STB;
    logic [7:0] oWR_ADDR;
    logic [7:0] oWR_DATA;
    logic       oBUSY;

    modport slave (
        input  iHOST_ADDR,
        output oHOST_DATA,
        output oWR_STB,
        output oWR_ADDR,
        output oWR_DATA,
        output oBUSY
    );

    modport master (
        output iHOST_ADDR,
        input  oHOST_DATA,
        input  oWR_STB,
        input  oWR_ADDR,
        input  oWR_DATA,
        input  oBUSY
    );

endinterface

// File: rtl/sccb_sync_edge.sv
// Brings SCL/SDA into the system clock domain and derives SCL edges and
// START/STOP conditions from the synchronized values.
module sccb_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;
    logic       scl_s;

    // Shift the raw lines through two stages and keep one more for edge history.
    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_in};
        sda_sync_d = {sda_sync_q[0], sda_in};
        scl_prev_d = scl_sync_q[1];
        sda_prev_d = sda_sync_q[1];
    end

    // Reset to the idle-bus level (both high) so reset release creates no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/sccb_slave_regfile.sv
// SCCB slave backed by a 256x8 register file with a host read port.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | bus free, waiting for START
// ST_ADDR      | shifting in the device address byte
// ST_ADDR_ACK  | driving ACK for a matching address
// ST_SUB       | shifting in the sub-address (register pointer)
// ST_SUB_ACK   | driving ACK for the sub-address
// ST_WDATA     | shifting in a data byte to write at ptr
// ST_WDATA_ACK | driving ACK for a written byte
// ST_RDATA     | shifting mem[ptr] out on SDA
// ST_RDATA_ACK | SDA released, sampling master ACK/NACK
// ST_IGNORE    | not addressed / read ended, wait for START or STOP
module sccb_slave_regfile
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = SCCB_WR_BYTE[7:1],
    parameter logic [7:0] REG_RESET = 8'h00
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 I2C_SCLK,
    inout  wire                  I2C_SDAT,
    sccb_slave_regfile_if.slave  host
);

    sccb_state_e          state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           ptr_q, ptr_d;
    logic                 sda_oe_q, sda_oe_d;
    logic                 busy_q, busy_d;
    logic                 wr_stb_q, wr_stb_d;
    logic [7:0]           wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic [7:0]           host_data_q, host_data_d;
    logic [7:0]           mem_q [256];
    logic [7:0]           mem_at_ptr;
    logic                 mem_we;
    logic                 rx_state;
    logic                 byte_done;

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    sccb_sync_edge u_sync (
        .clk       (iCLK),
        .rst_n     (iRST_N),
        .scl_in    (I2C_SCLK),
        .sda_in    (I2C_SDAT),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign mem_at_ptr = mem_q[ptr_q];
    assign rx_state   = (state_q == ST_ADDR) || (state_q == ST_SUB) || (state_q == ST_WDATA);
    assign byte_done  = scl_fall && (bit_cnt_q == BYTE_BITS);

    // Open-drain: only ever pull low; the flop clears asynchronously on reset.
    assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;

    // Protocol sequencing; START/STOP override whatever byte is in flight.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_we      = 1'b0;
        host_data_d = mem_q[host.iHOST_ADDR];

        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            if (rx_state && scl_rise) begin
                shift_d   = {shift_q[6:0], sda_s};
                bit_cnt_d = bit_cnt_q + 1'b1;
            end

            case (state_q)
                ST_ADDR: begin
                    if (byte_done) begin
                        bit_cnt_d = '0;
                        if (addr_hit(shift_q, DEV_ADDR)) begin
                            state_d  = ST_ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (shift_q[0]) begin
                            state_d  = ST_RDATA;
                            shift_d  = mem_at_ptr;
                            sda_oe_d = ~mem_at_ptr[7];
                        end else begin
                            state_d  = ST_SUB;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_SUB: begin
                    if (byte_done) begin
                        bit_cnt_d = '0;
                        ptr_d     = shift_q;
                        state_d   = ST_SUB_ACK;
                        sda_oe_d  = 1'b1;
                    end
                end
                ST_SUB_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d  = ST_WDATA;
                        sda_oe_d = 1'b0;
                    end
                end
                ST_WDATA: begin
                    if (byte_done) begin
                        bit_cnt_d = '0;
                        mem_we    = 1'b1;
                        wr_stb_d  = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = shift_q;
                        ptr_d     = ptr_q + 8'd1;
                        state_d   = ST_WDATA_ACK;
                        sda_oe_d  = 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (byte_done) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        state_d   = ST_RDATA_ACK;
                    end else if (scl_fall) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                ST_RDATA_ACK: begin
                    // ptr advances on the ACK so the following fall sees the next entry.
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = ST_IGNORE;
                        end else begin
                            ptr_d = ptr_q + 8'd1;
                        end
                    end else if (scl_fall) begin
                        state_d  = ST_RDATA;
                        shift_d  = mem_at_ptr;
                        sda_oe_d = ~mem_at_ptr[7];
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            host_data_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            host_data_q <= host_data_d;
        end
    end

    // Register file; a same-cycle host read sees the pre-write contents.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= REG_RESET;
            end
        end else if (mem_we) begin
            mem_q[ptr_q] <= shift_q;
        end
    end

    assign host.oHOST_DATA = host_data_q;
    assign host.oWR_STB    = wr_stb_q;
    assign host.oWR_ADDR   = wr_addr_q;
    assign host.oWR_DATA   = wr_data_q;
    assign host.oBUSY      = busy_q;

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Bench for sccb_slave_regfile: bit-banged SCCB master, transaction-level
// register-file model, and a write-strobe scoreboard.
module tb_sccb_slave_regfile;

    localparam logic [6:0] DEV     = 7'h21;
    localparam logic [7:0] RST_VAL = 8'h5A;
    localparam int         Q       = 125;

    logic clk;
    logic rst_n;
    logic scl;
    logic sda_low;
    wire  sda;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    sccb_slave_regfile_if hif ();

    sccb_slave_regfile #(
        .DEV_ADDR  (DEV),
        .REG_RESET (RST_VAL)
    ) dut (
        .iCLK     (clk),
        .iRST_N   (rst_n),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda),
        .host     (hif.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_ptr;
    logic [15:0] exp_wr [$];
    logic [7:0]  wbuf [4];

    initial begin
        clk = 1'b0;
        #2;
        forever #5 clk = ~clk;
    end

    initial begin
        #(3_000_000);
        $display("FAIL timeout: summary not reached within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every register write reported by the DUT must match the model.
    always @(negedge clk) begin
        if (rst_n && hif.oWR_STB) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_stb_unexpected: actual addr %0h data %0h required no strobe",
                         hif.oWR_ADDR, hif.oWR_DATA);
            end else begin
                check("wr_stb", 32'({hif.oWR_ADDR, hif.oWR_DATA}), 32'(exp_wr.pop_front()));
            end
        end
    end

    task automatic ref_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = RST_VAL;
        ref_ptr = 8'h00;
    endtask

    task automatic send_bit(input logic b);
        sda_low = !b;
        #(Q); scl = 1'b1;
        #(2*Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_low = 1'b0;
        #(Q); scl = 1'b1;
        #(Q); b = sda;
        #(Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic start_cond();
        sda_low = 1'b0;
        #(Q); scl = 1'b1;
        #(Q); sda_low = 1'b1;
        #(Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic stop_cond();
        sda_low = 1'b1;
        #(Q); scl = 1'b1;
        #(Q); sda_low = 1'b0;
        #(Q);
    endtask

    task automatic stop_check();
        stop_cond();
        #(Q);
        check("busy_after_stop", 32'(hif.oBUSY), 32'(0));
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    task automatic host_check(input logic [7:0] addr);
        hif.iHOST_ADDR = addr;
        repeat (2) @(posedge clk);
        #1;
        check("host_rd", 32'(hif.oHOST_DATA), 32'(ref_mem[addr]));
    endtask

    task automatic xact_write(input logic [6:0] dev, input logic [7:0] sub, input int n,
                              input logic do_stop);
        logic a;
        logic hit;
        hit = (dev == DEV);
        start_cond();
        send_byte({dev, 1'b0}, a);
        check("addr_wr_ack", 32'(a), 32'(!hit));
        check("busy_after_addr", 32'(hif.oBUSY), 32'(hit));
        send_byte(sub, a);
        check("sub_ack", 32'(a), 32'(!hit));
        if (hit) ref_ptr = sub;
        for (int i = 0; i < n; i++) begin
            if (hit) begin
                exp_wr.push_back({ref_ptr, wbuf[i]});
                ref_mem[ref_ptr] = wbuf[i];
                ref_ptr = ref_ptr + 8'd1;
            end
            send_byte(wbuf[i], a);
            check("data_ack", 32'(a), 32'(!hit));
        end
        if (do_stop) stop_check();
    endtask

    task automatic xact_read(input logic [6:0] dev, input int n);
        logic a;
        logic hit;
        logic [7:0] d;
        hit = (dev == DEV);
        start_cond();
        send_byte({dev, 1'b1}, a);
        check("addr_rd_ack", 32'(a), 32'(!hit));
        if (hit) begin
            for (int i = 0; i < n; i++) begin
                recv_byte(d);
                check("rd_data", 32'(d), 32'(ref_mem[ref_ptr]));
                send_bit(i == n - 1);
                if (i != n - 1) ref_ptr = ref_ptr + 8'd1;
            end
        end
        stop_check();
    endtask

    initial begin
        logic a;
        int   nbad;
        int   kind;
        int   n;
        logic [7:0] sub;
        logic [6:0] bad;

        rst_n = 1'b1;
        scl = 1'b1;
        sda_low = 1'b0;
        hif.iHOST_ADDR = 8'h00;
        ref_reset();
        #1 rst_n = 1'b0;
        #40;
        check("rst_wr_stb", 32'(hif.oWR_STB), 32'(0));
        check("rst_busy", 32'(hif.oBUSY), 32'(0));
        check("rst_host_data", 32'(hif.oHOST_DATA), 32'(0));
        check("rst_wr_addr", 32'({hif.oWR_ADDR, hif.oWR_DATA}), 32'(0));
        check("rst_sda", 32'(sda), 32'(1));
        #13 rst_n = 1'b1;
        #50;
        host_check(8'h00);
        host_check(8'hC3);

        // Bus activity with no START is ignored.
        #(Q); scl = 1'b0; #(Q);
        send_byte(8'h42, a);
        check("no_start_nack", 32'(a), 32'(1));
        stop_check();

        // Single register write.
        wbuf[0] = 8'h46;
        xact_write(DEV, 8'h12, 1, 1'b1);
        check("wr_hold", 32'({hif.oWR_ADDR, hif.oWR_DATA}), 32'(16'h1246));
        host_check(8'h12);

        // Wrong device address: no ACK anywhere, nothing written.
        wbuf[0] = 8'h99;
        xact_write(7'h20, 8'h12, 1, 1'b1);
        host_check(8'h12);

        // Sub-address only, repeated START, read with NACK; ptr stays put.
        xact_write(DEV, 8'h12, 0, 1'b0);
        xact_read(DEV, 1);
        xact_read(DEV, 1);

        // Write burst wrapping 0xFF -> 0x00, then a read burst across the wrap.
        wbuf[0] = 8'hAA;
        wbuf[1] = 8'hBB;
        xact_write(DEV, 8'hFF, 2, 1'b1);
        host_check(8'hFF);
        host_check(8'h00);
        xact_write(DEV, 8'hFF, 0, 1'b0);
        xact_read(DEV, 2);

        // STOP after half a data byte discards it.
        start_cond();
        send_byte(8'h42, a);
        check("partial_addr_ack", 32'(a), 32'(0));
        send_byte(8'h30, a);
        check("partial_sub_ack", 32'(a), 32'(0));
        ref_ptr = 8'h30;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        stop_check();
        host_check(8'h30);
        xact_read(DEV, 1);

        // Randomized mix of writes, reads and foreign-address traffic.
        for (int t = 0; t < 12; t++) begin
            kind = $urandom_range(0, 3);
            n    = $urandom_range(1, 3);
            sub  = 8'($urandom);
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
            case (kind)
                0: xact_write(DEV, sub, n, 1'b1);
                1: xact_read(DEV, n);
                2: begin
                    xact_write(DEV, sub, 0, 1'b0);
                    xact_read(DEV, n);
                end
                default: begin
                    bad = 7'($urandom);
                    if (bad == DEV) bad = DEV ^ 7'h01;
                    xact_write(bad, sub, n, 1'b1);
                end
            endcase
        end
        for (int i = 0; i < 6; i++) host_check(8'($urandom));

        // Reset during the address ACK low phase releases SDA immediately.
        start_cond();
        for (int i = 7; i >= 0; i--) send_bit(SCCB_BYTE_BIT(i));
        sda_low = 1'b0;
        #(Q);
        check("ack_driven", 32'(sda), 32'(0));
        rst_n = 1'b0;
        #1;
        check("rst_sda_release", 32'(sda), 32'(1));
        check("rst_busy_mid", 32'(hif.oBUSY), 32'(0));
        #30 rst_n = 1'b1;
        ref_reset();
        #(Q); scl = 1'b1; #(Q);
        nbad = 0;
        for (int i = 0; i < 256; i++) begin
            hif.iHOST_ADDR = 8'(i);
            repeat (2) @(posedge clk);
            #1;
            if (hif.oHOST_DATA !== RST_VAL) nbad++;
        end
        check("mem_after_reset", 32'(nbad), 32'(0));
        xact_read(DEV, 1);

        wbuf[0] = 8'h3C;
        wbuf[1] = 8'hC3;
        xact_write(DEV, 8'h80, 2, 1'b1);
        xact_write(DEV, 8'h80, 0, 1'b0);
        xact_read(DEV, 2);

        #(4*Q);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic SCCB_BYTE_BIT(input int i);
        logic [7:0] wr_byte;
        wr_byte = {DEV, 1'b0};
        return wr_byte[i];
    endfunction

endmodule
